// File: rtl/lz4_seq_encoder_if.sv
// Handshake bundle around the LZ4 sequence encoder: descriptor FIFO read port,
// literal byte stream in, encoded byte stream out.
interface lz4_seq_encoder_if;
    logic [46:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_valid;
    logic        fifo_rd_en;
    logic [7:0]  lit_data;
    logic        lit_valid;
    logic        lit_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        input  fifo_dout, fifo_empty, fifo_valid, lit_data, lit_valid, out_ready,
        output fifo_rd_en, lit_ready, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_valid, lit_data, lit_valid, out_ready,
        input  fifo_rd_en, lit_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/lz4_seq_encoder.sv
// Serialises one LZ4 sequence descriptor plus its literal bytes into the LZ4
// block byte format through a single registered output byte.
module lz4_seq_encoder #(
    parameter int LIT_W     = 14,
    parameter int ML_W      = 16,
    parameter int MIN_MATCH = 4
) (
    input  logic                clk,
    input  logic                rst,
    lz4_seq_encoder_if.master   bus,
    output logic                busy,
    output logic                err
);
    localparam int RW = (LIT_W > ML_W) ? LIT_W : ML_W;

    typedef enum logic [3:0] {
        S_IDLE, S_POP, S_WAIT, S_TOKEN, S_LEXT, S_LIT, S_OFF_LO, S_OFF_HI, S_MEXT
    } state_t;

    state_t state, state_n;

    logic [LIT_W-1:0] ll_q, cnt_q, cnt_n;
    logic [ML_W-1:0]  ml_q;
    logic [15:0]      off_q;
    logic             last_q;
    logic [RW-1:0]    rem_q, rem_n;
    logic [7:0]       out_data_q;
    logic             out_valid_q, out_last_q, err_q;

    logic             free, load, load_last, capture, rd_en, lit_rdy;
    logic [7:0]       load_byte;

    logic [LIT_W-1:0] f_ll;
    logic [ML_W-1:0]  f_ml;
    logic [15:0]      f_off;
    logic             f_last;
    logic             ll_big, ml_big, rem_big;
    logic [3:0]       tok_hi, tok_lo;

    assign f_last = bus.fifo_dout[46];
    assign f_ll   = bus.fifo_dout[32 +: LIT_W];
    assign f_off  = bus.fifo_dout[31:16];
    assign f_ml   = bus.fifo_dout[ML_W-1:0];

    assign ll_big  = ll_q >= LIT_W'(15);
    assign ml_big  = ml_q >= ML_W'(15);
    assign rem_big = rem_q >= RW'(255);
    assign tok_hi  = ll_big ? 4'hF : ll_q[3:0];
    assign tok_lo  = last_q ? 4'h0 : (ml_big ? 4'hF : ml_q[3:0]);

    // The output register is free when empty or being drained this cycle.
    assign free = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        rem_n     = rem_q;
        cnt_n     = cnt_q;
        load      = 1'b0;
        load_byte = 8'h00;
        load_last = 1'b0;
        capture   = 1'b0;
        rd_en     = 1'b0;
        lit_rdy   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_n = S_POP;
                end
            end
            S_POP, S_WAIT: begin
                if (bus.fifo_valid) begin
                    capture = 1'b1;
                    state_n = S_TOKEN;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_TOKEN: begin
                if (free) begin
                    load      = 1'b1;
                    load_byte = {tok_hi, tok_lo};
                    if (ll_big) begin
                        rem_n   = RW'(ll_q) - RW'(15);
                        state_n = S_LEXT;
                    end else if (ll_q != '0) begin
                        cnt_n   = ll_q;
                        state_n = S_LIT;
                    end else if (last_q) begin
                        load_last = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        state_n = S_OFF_LO;
                    end
                end
            end
            S_LEXT, S_MEXT: begin
                if (free) begin
                    load = 1'b1;
                    if (rem_big) begin
                        load_byte = 8'hFF;
                        rem_n     = rem_q - RW'(255);
                    end else begin
                        load_byte = rem_q[7:0];
                        cnt_n     = ll_q;
                        state_n   = (state == S_LEXT) ? S_LIT : S_IDLE;
                    end
                end
            end
            S_LIT: begin
                lit_rdy = free;
                if (free && bus.lit_valid) begin
                    load      = 1'b1;
                    load_byte = bus.lit_data;
                    cnt_n     = cnt_q - LIT_W'(1);
                    if (cnt_q == LIT_W'(1)) begin
                        load_last = last_q;
                        state_n   = last_q ? S_IDLE : S_OFF_LO;
                    end
                end
            end
            S_OFF_LO: begin
                if (free) begin
                    load      = 1'b1;
                    load_byte = off_q[7:0];
                    state_n   = S_OFF_HI;
                end
            end
            S_OFF_HI: begin
                if (free) begin
                    load      = 1'b1;
                    load_byte = off_q[15:8];
                    if (ml_big) begin
                        rem_n   = RW'(ml_q) - RW'(15);
                        state_n = S_MEXT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Descriptor capture, counters and the single registered output byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll_q        <= '0;
            ml_q        <= '0;
            off_q       <= '0;
            last_q      <= 1'b0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rem_q <= rem_n;
            cnt_q <= cnt_n;
            if (capture) begin
                ll_q   <= f_ll;
                off_q  <= f_off;
                last_q <= f_last;
                ml_q   <= (f_ml < ML_W'(MIN_MATCH)) ? '0 : f_ml - ML_W'(MIN_MATCH);
                if (!f_last && ((f_ml < ML_W'(MIN_MATCH)) || (f_off == 16'h0000)))
                    err_q <= 1'b1;
            end
            if (load) begin
                out_data_q  <= load_byte;
                out_last_q  <= load_last;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en && !rst;
    assign bus.lit_ready  = lit_rdy;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign busy           = (state != S_IDLE) || out_valid_q;
    assign err            = err_q;
endmodule

// File: tb/tb_lz4_seq_encoder.sv
// Self-checking bench for lz4_seq_encoder: a byte-stream model of the LZ4
// sequence format, a FIFO/literal source model and a per-cycle output checker.
module tb_lz4_seq_encoder;
    logic clk = 1'b0;
    logic rst;
    logic busy, err;

    always #5 clk = ~clk;

    lz4_seq_encoder_if bus();

    lz4_seq_encoder #(.LIT_W(14), .ML_W(16), .MIN_MATCH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [46:0] descQ[$];
    logic [7:0]  litQ[$];
    logic [9:0]  expQ[$];
    logic [8:0]  gotLog[$];

    bit          pendingValid = 1'b0;
    logic [46:0] pendingData;
    int          readyPct = 100;
    int          litPct = 100;
    bit          chkLat = 1'b0;
    bit          armed = 1'b0;
    int          popCycle = 0;
    bit          prevStall = 1'b0;
    logic [7:0]  prevData;
    logic        prevLast;
    bit          expErr = 1'b0;

    task automatic expectEq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: builds the expected byte stream straight from the LZ4 sequence rules.
    task automatic modelEncode(input bit last, input int ll, input int off, input int mlraw, input int litStart);
        int ml, r, hi, lo;
        logic [7:0] b;
        ml = (mlraw < 4) ? 0 : mlraw - 4;
        if (!last && (mlraw < 4 || off == 0)) expErr = 1'b1;
        descQ.push_back({last, 14'(ll), 16'(off), 16'(mlraw)});
        hi = (ll < 15) ? ll : 15;
        lo = last ? 0 : ((ml < 15) ? ml : 15);
        expQ.push_back({1'b1, last && (ll == 0), 8'(hi * 16 + lo)});
        if (ll >= 15) begin
            r = ll - 15;
            while (r >= 255) begin
                expQ.push_back({2'b00, 8'hFF});
                r -= 255;
            end
            expQ.push_back({2'b00, 8'(r)});
        end
        for (int i = 0; i < ll; i++) begin
            b = (litStart >= 0) ? 8'(litStart + i) : 8'($urandom_range(255));
            litQ.push_back(b);
            expQ.push_back({1'b0, last && (i == ll - 1), b});
        end
        if (!last) begin
            expQ.push_back({2'b00, 8'(off % 256)});
            expQ.push_back({2'b00, 8'(off / 256)});
            if (ml >= 15) begin
                r = ml - 15;
                while (r >= 255) begin
                    expQ.push_back({2'b00, 8'hFF});
                    r -= 255;
                end
                expQ.push_back({2'b00, 8'(r)});
            end
        end
    endtask

    task automatic applyStimulus();
        bus.fifo_valid = pendingValid;
        bus.fifo_dout  = pendingValid ? pendingData : 47'({$urandom(), $urandom()});
        pendingValid   = 1'b0;
        bus.fifo_empty = (descQ.size() == 0);
        bus.lit_valid  = (litQ.size() > 0) && (int'($urandom_range(99)) < litPct);
        bus.lit_data   = (litQ.size() > 0) ? litQ[0] : 8'h00;
        bus.out_ready  = int'($urandom_range(99)) < readyPct;
    endtask

    task automatic checkOutput();
        logic [9:0] e;
        cyc++;
        if (rst) begin
            prevStall = 1'b0;
            armed = 1'b0;
        end else begin
            if (prevStall) begin
                expectEq("hold_valid", 32'(bus.out_valid), 32'd1);
                expectEq("hold_data", 32'(bus.out_data), 32'(prevData));
                expectEq("hold_last", 32'(bus.out_last), 32'(prevLast));
            end
            if (armed && bus.out_valid && expQ.size() > 0 && expQ[0][9]) begin
                if (chkLat) expectEq("latency", 32'(cyc - popCycle), 32'd3);
                armed = 1'b0;
            end
            if (bus.fifo_rd_en) begin
                if (descQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_on_empty got rd_en 1 expected 0");
                end else begin
                    pendingData  = descQ.pop_front();
                    pendingValid = 1'b1;
                end
                popCycle = cyc;
                armed = 1'b1;
            end
            if (bus.lit_valid && bus.lit_ready) void'(litQ.pop_front());
            if (bus.out_valid && bus.out_ready) begin
                gotLog.push_back({bus.out_last, bus.out_data});
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_byte got %0h expected none", bus.out_data);
                end else begin
                    e = expQ.pop_front();
                    expectEq("out_byte", 32'(bus.out_data), 32'(e[7:0]));
                    expectEq("out_last", 32'(bus.out_last), 32'(e[8]));
                end
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
        end
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        @(negedge clk);
        while ((expQ.size() != 0 || descQ.size() != 0 || pendingValid || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout got %0d bytes pending expected 0", name, expQ.size());
        end
        expectEq({name, "_err"}, 32'(err), 32'(expErr));
        expectEq({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pinLog(input string name, input int idx, input logic [8:0] exp);
        if (idx < gotLog.size()) expectEq(name, 32'(gotLog[idx]), 32'(exp));
        else expectEq({name, "_missing"}, 32'(gotLog.size()), 32'(idx + 1));
    endtask

    initial forever begin
        @(negedge clk);
        checkOutput();
    end

    initial forever begin
        @(posedge clk);
        #1;
        applyStimulus();
    end

    initial begin
        int ll, ml, off, n;
        bit last;
        logic [8:0] pin1 [6];
        pin1 = '{9'h032, 9'h041, 9'h042, 9'h043, 9'h002, 9'h001};

        rst = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_valid = 1'b0;
        bus.fifo_dout  = '0;
        bus.lit_valid  = 1'b0;
        bus.lit_data   = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        expectEq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        expectEq("rst_busy", 32'(busy), 32'd0);
        expectEq("rst_err", 32'(err), 32'd0);
        expectEq("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst = 1'b0;

        chkLat = 1'b1;
        gotLog.delete();
        modelEncode(1'b0, 3, 'h0102, 6, 'h41);
        waitDone("case1");
        expectEq("case1_len", 32'(gotLog.size()), 32'd6);
        for (int i = 0; i < 6; i++) pinLog("case1_pin", i, pin1[i]);

        gotLog.delete();
        modelEncode(1'b0, 15, 1, 19, 'h10);
        waitDone("case2");
        pinLog("case2_tok", 0, 9'h0FF);
        pinLog("case2_lext", 1, 9'h000);
        pinLog("case2_offlo", 17, 9'h001);
        pinLog("case2_mext", 19, 9'h000);

        gotLog.delete();
        modelEncode(1'b0, 300, 8, 4, -1);
        waitDone("case3");
        pinLog("case3_tok", 0, 9'h0F0);
        pinLog("case3_ext0", 1, 9'h0FF);
        pinLog("case3_ext1", 2, 9'h01E);
        pinLog("case3_offlo", 303, 9'h008);

        gotLog.delete();
        modelEncode(1'b1, 0, 0, 0, -1);
        modelEncode(1'b1, 5, 0, 0, 'h60);
        waitDone("case4");
        pinLog("case4_lastonly", 0, 9'h100);
        pinLog("case4_tok", 1, 9'h050);
        pinLog("case4_lastlit", 6, 9'h164);

        chkLat = 1'b0;
        readyPct = 50;
        litPct = 70;
        modelEncode(1'b0, 3, 'h0102, 6, 'h41);
        modelEncode(1'b0, 15, 1, 19, 'h10);
        modelEncode(1'b0, 300, 8, 4, -1);
        for (int k = 0; k < 40; k++) begin
            last = ($urandom_range(7) == 0);
            n = int'($urandom_range(9));
            ll = (n < 6) ? int'($urandom_range(20)) : (n < 9) ? int'($urandom_range(80, 15)) : int'($urandom_range(700, 250));
            n = int'($urandom_range(9));
            ml = (n < 6) ? int'($urandom_range(30, 4)) : int'($urandom_range(600, 4));
            off = last ? int'($urandom_range(65535)) : int'($urandom_range(65535, 1));
            modelEncode(last, ll, off, ml, -1);
        end
        waitDone("random");

        readyPct = 100;
        litPct = 100;
        gotLog.delete();
        modelEncode(1'b0, 0, 5, 2, -1);
        waitDone("case6");
        expectEq("case6_err", 32'(err), 32'd1);
        pinLog("case6_tok", 0, 9'h000);
        pinLog("case6_offlo", 1, 9'h005);
        modelEncode(1'b0, 2, 9, 8, 'h70);
        waitDone("case6_sticky");

        litPct = 30;
        gotLog.delete();
        modelEncode(1'b0, 20, 'h33, 40, -1);
        n = 0;
        while (gotLog.size() < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        expectEq("midlit_reached", 32'(gotLog.size() >= 4), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expectEq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        expectEq("arst_lit_ready", 32'(bus.lit_ready), 32'd0);
        expectEq("arst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        descQ.delete();
        litQ.delete();
        expQ.delete();
        pendingValid = 1'b0;
        expErr = 1'b0;
        repeat (2) @(negedge clk);
        expectEq("arst_busy", 32'(busy), 32'd0);
        expectEq("arst_err", 32'(err), 32'd0);
        expectEq("arst_out_last", 32'(bus.out_last), 32'd0);
        rst = 1'b0;

        litPct = 100;
        gotLog.delete();
        modelEncode(1'b0, 3, 'h0102, 6, 'h41);
        waitDone("recover");
        for (int i = 0; i < 6; i++) pinLog("recover_pin", i, pin1[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
